// File: rtl/serial_alu_rx_if.sv
// Bus between the serial pin driver and the ALU serial frame receiver.
// The receiver takes the slave modport; the pin/stimulus side takes master.
interface serial_alu_rx_if #(
    parameter int OP_W = 32
);
    logic            sin;
    logic            out_valid;
    logic [OP_W-1:0] out_b;
    logic [OP_W-1:0] out_a;
    logic [2:0]      out_op;
    logic [2:0]      err_flags;
    logic            err_frame;

    modport master (
        output sin,
        input  out_valid, out_b, out_a, out_op, err_flags, err_frame
    );

    modport slave (
        input  sin,
        output out_valid, out_b, out_a, out_op, err_flags, err_frame
    );
endinterface

// File: rtl/serial_alu_rx.sv
// ALU serial frame receiver: deserialises operands B/A, opcode and CRC4, flags errors, aborts stalled frames.
// Optional macro SERIAL_ALU_RX_SYNC_EN inserts a 2-flop synchroniser on sin (adds 2 cycles of latency).
module serial_alu_rx #(
    parameter int OP_W    = 32,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst,
    serial_alu_rx_if.slave bus
);
    localparam int DW     = 2 * OP_W;
    localparam int NBYTES = DW / 8;
    localparam int CNT_W  = $clog2(NBYTES + 2);
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBYTES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBYTES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TYPE = 2'd1;
    localparam logic [1:0] S_BITS = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic sin_s;

`ifdef SERIAL_ALU_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.sin};
    end
    assign sin_s = sync_q[1];
`else
    assign sin_s = bus.sin;
`endif

    logic [1:0]      state_q, state_d;
    logic            type_q, type_d;
    logic [7:0]      sh_q, sh_d;
    logic [2:0]      bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DW-1:0]   data_q, data_d;
    logic            out_valid_q, out_valid_d;
    logic [OP_W-1:0] out_b_q, out_b_d;
    logic [OP_W-1:0] out_a_q, out_a_d;
    logic [2:0]      out_op_q, out_op_d;
    logic [2:0]      err_q, err_d;
    logic            err_frame_q, err_frame_d;

    // Message is {B, A, 1, op, 0000}, fed MSB first into r.
    function automatic logic [3:0] crc4(input logic [DW-1:0] data, input logic [2:0] op);
        logic [DW+7:0] msg;
        logic [3:0]    r;
        msg = {data, 1'b1, op, 4'b0000};
        r   = 4'b0000;
        for (int i = DW + 7; i >= 0; i--) begin
            r = {r[2], r[1], r[3] ^ r[0], r[3] ^ msg[i]};
        end
        return r;
    endfunction

    function automatic logic [2:0] frame_flags(input logic [CNT_W-1:0] cnt,
                                               input logic [DW-1:0]    data,
                                               input logic [6:0]       ctl);
        if (cnt != CNT_FULL)                      return 3'b100;
        else if (crc4(data, ctl[6:4]) != ctl[3:0]) return 3'b010;
        else if (ctl[5])                          return 3'b001;
        else                                      return 3'b000;
    endfunction

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        out_b_d     = out_b_q;
        out_a_d     = out_a_q;
        out_op_d    = out_op_q;
        err_d       = err_q;
        err_frame_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sin_s) begin
                    state_d = S_TYPE;
                    tmo_d   = '0;
                end else if (cnt_q != '0 && TIMEOUT != 0) begin
                    if (tmo_q == TMO_LAST) begin
                        err_frame_d = 1'b1;
                        cnt_d       = '0;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            S_TYPE: begin
                type_d  = sin_s;
                bit_d   = 3'd0;
                state_d = S_BITS;
            end
            S_BITS: begin
                sh_d  = {sh_q[6:0], sin_s};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_STOP;
            end
            default: begin
                state_d = S_IDLE;
                if (!sin_s) begin
                    err_frame_d = 1'b1;
                    cnt_d       = '0;
                end else if (!type_q) begin
                    data_d = {data_q[DW-9:0], sh_q};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_b_d     = data_q[DW-1:OP_W];
                    out_a_d     = data_q[OP_W-1:0];
                    out_op_d    = sh_q[6:4];
                    err_d       = frame_flags(cnt_q, data_q, sh_q[6:0]);
                    cnt_d       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_b_q     <= '0;
            out_a_q     <= '0;
            out_op_q    <= '0;
            err_q       <= '0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_b_q     <= out_b_d;
            out_a_q     <= out_a_d;
            out_op_q    <= out_op_d;
            err_q       <= err_d;
            err_frame_q <= err_frame_d;
        end
    end

    // Shift/assembly registers are always overwritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        type_q <= type_d;
        sh_q   <= sh_d;
        bit_q  <= bit_d;
        data_q <= data_d;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_op    = out_op_q;
    assign bus.err_flags = err_q;
    assign bus.err_frame = err_frame_q;
endmodule

// File: tb/tb_serial_alu_rx.sv
// Directed bench for serial_alu_rx (OP_W=32, TIMEOUT=64): good/bad frames, timeout, back-to-back, resets.
module tb_serial_alu_rx;
    localparam int OP_W    = 32;
    localparam int TIMEOUT = 64;
`ifdef SERIAL_ALU_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   vld_seen = 0;
    int   ferr_seen = 0;
    int   vld_last = 0;
    int   vld_prev = 0;

    serial_alu_rx_if #(.OP_W(OP_W)) bus ();

    serial_alu_rx #(.OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            vld_seen <= vld_seen + 1;
            vld_prev <= vld_last;
            vld_last <= cyc;
        end
        if (bus.err_frame === 1'b1) ferr_seen <= ferr_seen + 1;
    end

    // Reference CRC4 straight from the protocol definition.
    function automatic logic [3:0] crc_model(input logic [63:0] ba, input logic [2:0] op);
        logic [71:0] m;
        logic [3:0]  r;
        m = {ba, 1'b1, op, 4'b0000};
        r = 4'h0;
        for (int i = 71; i >= 0; i--) r = {r[2], r[1], r[3] ^ r[0], r[3] ^ m[i]};
        return r;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.sin = b;
    endtask

    task automatic send_byte(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_data(input logic [63:0] ba, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(1'b0, ba[63-8*i -: 8], 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.sin = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_b, bus.out_a, bus.out_op, bus.err_flags, bus.err_frame} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got b=%h a=%h v=%b op=%b fl=%b fe=%b, expected all 0",
                     bus.out_b, bus.out_a, bus.out_valid, bus.out_op, bus.err_flags, bus.err_frame);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_b, bus.out_a, bus.out_op, bus.err_flags, bus.err_frame} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got b=%h a=%h v=%b fe=%b, expected all 0",
                     bus.out_b, bus.out_a, bus.out_valid, bus.err_frame);
        end
    endtask

    task automatic test_good_frame;
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags, bus.err_frame} !== {1'b1, 3'b000, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL good_frame: got v=%b op=%b fl=%b fe=%b, expected v=1 op=000 fl=000 fe=0",
                     bus.out_valid, bus.out_op, bus.err_flags, bus.err_frame);
        end
        n_chk++;
        if ({bus.out_b, bus.out_a} !== 64'h0) begin
            n_fail++;
            $display("FAIL good_frame_ops: got b=%h a=%h, expected 0/0", bus.out_b, bus.out_a);
        end
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame_pulse_width: got v=%b one cycle later, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flag_errors;
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0A, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags} !== {1'b1, 3'b000, 3'b010}) begin
            n_fail++;
            $display("FAIL crc_err: got v=%b op=%b fl=%b, expected v=1 op=000 fl=010",
                     bus.out_valid, bus.out_op, bus.err_flags);
        end
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h2D, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags} !== {1'b1, 3'b010, 3'b001}) begin
            n_fail++;
            $display("FAIL op_err: got v=%b op=%b fl=%b, expected v=1 op=010 fl=001",
                     bus.out_valid, bus.out_op, bus.err_flags);
        end
    endtask

    task automatic test_operands;
        logic [63:0] ba;
        logic [3:0]  crc;
        ba  = 64'h12345678_9ABCDEF0;
        crc = crc_model(ba, 3'b101);
        send_data(ba, 8);
        send_byte(1'b1, {1'b0, 3'b101, crc}, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a} !== {1'b1, 3'b101, 3'b000, ba}) begin
            n_fail++;
            $display("FAIL operands_good: got v=%b op=%b fl=%b b=%h a=%h, expected v=1 op=101 fl=000 b=%h a=%h",
                     bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a, ba[63:32], ba[31:0]);
        end
        repeat (6) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a} !== {1'b0, 3'b101, 3'b000, ba}) begin
            n_fail++;
            $display("FAIL operands_hold: got v=%b op=%b b=%h a=%h, expected v=0 op=101 b=%h a=%h",
                     bus.out_valid, bus.out_op, bus.out_b, bus.out_a, ba[63:32], ba[31:0]);
        end
        ba  = 64'h9ABCDEF0_12345678;
        crc = crc_model(ba, 3'b100) ^ 4'h1;
        send_data(ba, 8);
        send_byte(1'b1, {1'b0, 3'b100, crc}, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a} !== {1'b1, 3'b100, 3'b010, ba}) begin
            n_fail++;
            $display("FAIL operands_crc_err: got v=%b op=%b fl=%b b=%h a=%h, expected v=1 op=100 fl=010 b=%h a=%h",
                     bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a, ba[63:32], ba[31:0]);
        end
    endtask

    task automatic test_byte_count;
        send_data(64'h0, 7);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b100}) begin
            n_fail++;
            $display("FAIL short_frame: got v=%b fl=%b, expected v=1 fl=100", bus.out_valid, bus.err_flags);
        end
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL after_short_good: got v=%b fl=%b, expected v=1 fl=000", bus.out_valid, bus.err_flags);
        end
        send_data(64'h0, 8);
        send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b100}) begin
            n_fail++;
            $display("FAIL long_frame: got v=%b fl=%b, expected v=1 fl=100", bus.out_valid, bus.err_flags);
        end
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b100}) begin
            n_fail++;
            $display("FAIL stray_ctl: got v=%b fl=%b, expected v=1 fl=100", bus.out_valid, bus.err_flags);
        end
    endtask

    task automatic test_timeout;
        int v0, f0;
        repeat (3) @(negedge clk);
        #1;
        v0 = vld_seen;
        f0 = ferr_seen;
        send_data(64'h11223344_55667788, 3);
        repeat (TIMEOUT + LAT) @(negedge clk);
        n_chk++;
        if (bus.err_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got err_frame=%b after %0d idle cycles, expected 0", bus.err_frame, TIMEOUT - 1);
        end
        @(negedge clk);
        n_chk++;
        if (bus.err_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got err_frame=%b after %0d idle cycles, expected 1", bus.err_frame, TIMEOUT);
        end
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ((ferr_seen - f0) !== 1 || (vld_seen - v0) !== 0) begin
            n_fail++;
            $display("FAIL timeout_counts: got err_frame pulses=%0d valid pulses=%0d, expected 1 and 0",
                     ferr_seen - f0, vld_seen - v0);
        end
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags, bus.err_frame} !== {1'b1, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL after_timeout_good: got v=%b fl=%b fe=%b, expected v=1 fl=000 fe=0",
                     bus.out_valid, bus.err_flags, bus.err_frame);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        @(negedge clk);
        #1;
        v0 = vld_seen;
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 2) @(negedge clk);
        #1;
        n_chk++;
        if ((vld_seen - v0) !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d valid pulses, expected 2", vld_seen - v0);
        end
        n_chk++;
        if ((vld_last - vld_prev) !== 99) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles between pulses, expected 99", vld_last - vld_prev);
        end
        n_chk++;
        if (bus.err_flags !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_flags: got fl=%b, expected 000", bus.err_flags);
        end
    endtask

    task automatic test_stop_error;
        int v0, f0;
        #1;
        v0 = vld_seen;
        f0 = ferr_seen;
        send_byte(1'b0, 8'hA5, 1'b1);
        send_byte(1'b0, 8'h5A, 1'b0);
        @(negedge clk);
        bus.sin = 1'b1;
        repeat (LAT) @(negedge clk);
        n_chk++;
        if (bus.err_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_err_pulse: got err_frame=%b, expected 1", bus.err_frame);
        end
        repeat (10) @(negedge clk);
        #1;
        n_chk++;
        if ((ferr_seen - f0) !== 1 || (vld_seen - v0) !== 0) begin
            n_fail++;
            $display("FAIL stop_err_counts: got err_frame pulses=%0d valid pulses=%0d, expected 1 and 0",
                     ferr_seen - f0, vld_seen - v0);
        end
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL after_stop_err_good: got v=%b fl=%b, expected v=1 fl=000", bus.out_valid, bus.err_flags);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] ba;
        int          v0;
        ba = 64'hCAFEF00D_0BADBEEF;
        send_data(ba, 8);
        send_byte(1'b1, {1'b0, 3'b001, crc_model(ba, 3'b001)}, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a} !== {1'b1, 3'b001, 3'b000, ba}) begin
            n_fail++;
            $display("FAIL pre_reset_frame: got v=%b op=%b fl=%b b=%h a=%h, expected v=1 op=001 fl=000 b=%h a=%h",
                     bus.out_valid, bus.out_op, bus.err_flags, bus.out_b, bus.out_a, ba[63:32], ba[31:0]);
        end
        send_data(ba, 4);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.sin = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.out_b, bus.out_a, bus.out_op, bus.err_flags, bus.err_frame} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got b=%h a=%h v=%b op=%b fl=%b fe=%b, expected all 0",
                     bus.out_b, bus.out_a, bus.out_valid, bus.out_op, bus.err_flags, bus.err_frame);
        end
        rst = 1'b0;
        #1;
        v0 = vld_seen;
        repeat (20) @(negedge clk);
        #1;
        n_chk++;
        if ((vld_seen - v0) !== 0 || bus.err_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_pulse: got %0d valid pulses fe=%b, expected 0 and 0", vld_seen - v0, bus.err_frame);
        end
        send_data(64'h0, 8);
        send_byte(1'b1, 8'h0B, 1'b1);
        repeat (LAT + 1) @(negedge clk);
        n_chk++;
        if ({bus.out_valid, bus.err_flags} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL after_mid_reset_good: got v=%b fl=%b, expected v=1 fl=000", bus.out_valid, bus.err_flags);
        end
    endtask

    initial begin
        bus.sin = 1'b1;
        test_reset();
        test_good_frame();
        test_flag_errors();
        test_operands();
        test_byte_count();
        test_timeout();
        test_back_to_back();
        test_stop_error();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
